// File: rtl/alu_control_md.sv
// EX-stage ALU control: combinational base decode plus an RV32M/RV64M multiply sequencer and radix-2 divider.
// Base decode has no latency; M-ops stall the pipeline via md_stall until a one-cycle md_valid strobe.
module alu_control_md #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int ENABLE_M   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            flush,
  input  logic [1:0]      AluOp,
  input  logic            is_rtype,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic [3:0]      alu_control,
  output logic            illegal,
  output logic            md_stall,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            m_pat, m_op, accept, sub_sel;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] a_q, b_q, rem_q;
  logic            qneg_q, rneg_q;

  assign m_pat   = (AluOp == 2'b10) && is_rtype && (funct7 == 7'b0000001);
  assign m_op    = m_pat && (ENABLE_M != 0);
  assign accept  = (state == IDLE) && ex_valid && m_op && !flush;
  assign sub_sel = is_rtype & funct7[5];

  always_comb begin
    alu_control = 4'b1111;
    case (AluOp)
      2'b00: alu_control = 4'b0010;
      2'b01: alu_control = 4'b0110;
      2'b10: begin
        if (m_pat) begin
          alu_control = (ENABLE_M != 0) ? 4'b1010 : 4'b1111;
        end else begin
          case (funct3)
            3'b000:  alu_control = sub_sel ? 4'b0110 : 4'b0010;
            3'b001:  alu_control = 4'b0100;
            3'b010:  alu_control = 4'b0111;
            3'b011:  alu_control = 4'b1000;
            3'b100:  alu_control = 4'b0011;
            3'b101:  alu_control = sub_sel ? 4'b1001 : 4'b0101;
            3'b110:  alu_control = 4'b0001;
            default: alu_control = 4'b0000;
          endcase
        end
      end
      default: alu_control = 4'b1111;
    endcase
  end

  assign illegal  = (alu_control == 4'b1111);
  assign md_stall = rst_n && ex_valid && m_op && (state != DONE);
  assign md_valid = (state == DONE) && !flush;

  // Multiply: operands come straight from the inputs on the accept cycle (MUL_STAGES=1), else from latches.
  logic [XLEN-1:0]   ma, mb, mul_res;
  logic [2:0]        mf3;
  logic              ma_sgn, mb_sgn;
  logic [2*XLEN-1:0] ma_ext, mb_ext, prod;

  assign ma      = (state == IDLE) ? rs1_val : a_q;
  assign mb      = (state == IDLE) ? rs2_val : b_q;
  assign mf3     = (state == IDLE) ? funct3  : f3_q;
  assign ma_sgn  = (mf3 == 3'b001) || (mf3 == 3'b010);
  assign mb_sgn  = (mf3 == 3'b001);
  assign ma_ext  = {{XLEN{ma_sgn & ma[XLEN-1]}}, ma};
  assign mb_ext  = {{XLEN{mb_sgn & mb[XLEN-1]}}, mb};
  assign prod    = ma_ext * mb_ext;
  assign mul_res = (mf3 == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Divide: a_q shifts the dividend magnitude out while the quotient shifts in.
  logic            sgn_in, a_neg, b_neg, div_zero, div_ovf, ge;
  logic [XLEN:0]   shl, diff;
  logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix, div_res, spec_res, done_res;

  assign sgn_in   = ~funct3[0];
  assign a_neg    = sgn_in & rs1_val[XLEN-1];
  assign b_neg    = sgn_in & rs2_val[XLEN-1];
  assign div_zero = (rs2_val == '0);
  assign div_ovf  = sgn_in && (rs1_val == MIN) && (rs2_val == '1);
  assign spec_res = div_zero ? (funct3[1] ? rs1_val : '1) : (funct3[1] ? '0 : MIN);

  assign shl     = {rem_q, a_q[XLEN-1]};
  assign diff    = shl - {1'b0, b_q};
  assign ge      = (shl >= {1'b0, b_q});
  assign rem_nx  = ge ? diff[XLEN-1:0] : shl[XLEN-1:0];
  assign quo_nx  = {a_q[XLEN-2:0], ge};
  assign q_fix   = qneg_q ? -quo_nx : quo_nx;
  assign r_fix   = rneg_q ? -rem_nx : rem_nx;
  assign div_res = f3_q[1] ? r_fix : q_fix;

  always_comb begin
    done_res = div_res;
    if (state == IDLE) done_res = funct3[2] ? spec_res : mul_res;
    else if (state == MUL) done_res = mul_res;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (flush) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt_nx = '0;
            if (!funct3[2]) state_nx = (MUL_STAGES == 1) ? DONE : MUL;
            else            state_nx = (div_zero || div_ovf) ? DONE : DIV;
          end
        end
        MUL: begin
          if (cnt == CW'(MUL_STAGES - 2)) begin
            state_nx = DONE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        DIV: begin
          if (cnt == CW'(XLEN - 1)) begin
            state_nx = DONE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      md_result <= '0;
    end else begin
      if (accept) begin
        f3_q <= funct3;
        if (!funct3[2]) begin
          a_q <= rs1_val;
          b_q <= rs2_val;
        end else begin
          a_q    <= a_neg ? -rs1_val : rs1_val;
          b_q    <= b_neg ? -rs2_val : rs2_val;
          rem_q  <= '0;
          qneg_q <= a_neg ^ b_neg;
          rneg_q <= a_neg;
        end
      end else if (state == DIV && !flush) begin
        a_q   <= quo_nx;
        rem_q <= rem_nx;
      end
      if (state_nx == DONE && state != DONE) md_result <= done_res;
    end
  end
endmodule

// File: tb/tb_alu_control_md.sv
// Bench for alu_control_md: decode tables, M-op latency/stall counts, corner cases, flush and async reset.
// A negedge monitor pops expected md_result values from a queue on every md_valid strobe.
module tb_alu_control_md;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n, ex_valid, flush, is_rtype;
  logic [1:0]  AluOp;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [3:0]  alu_control, nm_alu_control;
  logic        illegal, md_stall, md_valid;
  logic        nm_illegal, nm_md_stall, nm_md_valid;
  logic [31:0] md_result, nm_md_result, sb_exp;

  int checks = 0, failures = 0, vcount = 0, vcount_nm = 0;
  logic [31:0] sb_q[$];

  typedef struct packed {
    logic [1:0] ao;
    logic       rt;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] ctl;
  } dec_t;

  always #5 clk = ~clk;

  alu_control_md #(.XLEN(32), .MUL_STAGES(2), .ENABLE_M(1)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .flush(flush), .AluOp(AluOp),
    .is_rtype(is_rtype), .funct7(funct7), .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .alu_control(alu_control), .illegal(illegal), .md_stall(md_stall), .md_valid(md_valid),
    .md_result(md_result));

  alu_control_md #(.XLEN(32), .MUL_STAGES(2), .ENABLE_M(0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .flush(flush), .AluOp(AluOp),
    .is_rtype(is_rtype), .funct7(funct7), .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .alu_control(nm_alu_control), .illegal(nm_illegal), .md_stall(nm_md_stall),
    .md_valid(nm_md_valid), .md_result(nm_md_result));

  always @(negedge clk) begin
    if (nm_md_valid) vcount_nm++;
    if (md_valid) begin
      vcount++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected md_valid md_result=%h with no pending op", md_result);
      end else begin
        sb_exp = sb_q.pop_front();
        if (md_result !== sb_exp) begin
          failures++;
          $display("FAIL sb_result got=%h exp=%h", md_result, sb_exp);
        end
      end
    end
  end

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == MIN && b == 32'hFFFF_FFFF) r = MIN;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin p = ua / ub; r = p[31:0]; end
      end
      3'd6: begin
        if (b == 0) r = a;
        else if (a == MIN && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 0 || (!f3[0] && a == MIN && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  task automatic drive_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    ex_valid = 1'b1; flush = 1'b0; AluOp = 2'b10; is_rtype = 1'b1;
    funct7 = 7'b0000001; funct3 = f3; rs1_val = a; rs2_val = b;
  endtask

  // Issues one M-op, scrambles operands after acceptance, measures latency and stall cycles.
  task automatic run_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int lat_exp);
    int lat, st;
    bit got;
    @(posedge clk); #1;
    drive_mop(f3, a, b);
    sb_q.push_back(e);
    lat = 0; st = 0; got = 0;
    while (!got && lat <= 60) begin
      @(negedge clk);
      if (md_valid) got = 1;
      else begin
        if (md_stall) st++;
        @(posedge clk); #1;
        rs1_val = $urandom; rs2_val = $urandom;
        lat++;
      end
    end
    checks++;
    if (!got || lat != lat_exp) begin
      failures++;
      $display("FAIL latency f3=%0d got=%0d exp=%0d done=%0d", f3, lat, lat_exp, got);
      if (!got) sb_q.delete();
    end
    checks++;
    if (st != lat_exp) begin
      failures++;
      $display("FAIL stall_cycles f3=%0d got=%0d exp=%0d", f3, st, lat_exp);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    ex_valid = 1'b0; flush = 1'b0; AluOp = 2'b00; is_rtype = 1'b0; funct7 = '0; funct3 = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_valid = 1'b0; flush = 1'b0; AluOp = 2'b00; is_rtype = 1'b0;
    funct7 = '0; funct3 = '0; rs1_val = '0; rs2_val = '0;
    #12;
    checks++;
    if ({md_stall, md_valid, md_result} !== 34'h0) begin
      failures++;
      $display("FAIL reset_state stall=%b valid=%b result=%h exp 0/0/0", md_stall, md_valid, md_result);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_decode();
    dec_t tbl[14];
    logic [3:0] nm_exp;
    tbl = '{
      '{2'b00, 1'b0, 7'h00, 3'b000, 4'b0010}, '{2'b01, 1'b0, 7'h00, 3'b000, 4'b0110},
      '{2'b11, 1'b1, 7'h00, 3'b000, 4'b1111}, '{2'b10, 1'b1, 7'h20, 3'b101, 4'b1001},
      '{2'b10, 1'b0, 7'h20, 3'b101, 4'b0101}, '{2'b10, 1'b0, 7'h20, 3'b000, 4'b0010},
      '{2'b10, 1'b1, 7'h20, 3'b000, 4'b0110}, '{2'b10, 1'b1, 7'h00, 3'b111, 4'b0000},
      '{2'b10, 1'b1, 7'h00, 3'b110, 4'b0001}, '{2'b10, 1'b1, 7'h00, 3'b100, 4'b0011},
      '{2'b10, 1'b1, 7'h00, 3'b001, 4'b0100}, '{2'b10, 1'b1, 7'h00, 3'b010, 4'b0111},
      '{2'b10, 1'b1, 7'h00, 3'b011, 4'b1000}, '{2'b10, 1'b1, 7'h01, 3'b100, 4'b1010}
    };
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      ex_valid = 1'b0; AluOp = tbl[i].ao; is_rtype = tbl[i].rt; funct7 = tbl[i].f7; funct3 = tbl[i].f3;
      #2;
      nm_exp = (tbl[i].ao == 2'b10 && tbl[i].rt && tbl[i].f7 == 7'h01) ? 4'b1111 : tbl[i].ctl;
      checks++;
      if (alu_control !== tbl[i].ctl || illegal !== (tbl[i].ctl == 4'b1111)) begin
        failures++;
        $display("FAIL decode[%0d] ctl=%b ill=%b exp ctl=%b", i, alu_control, illegal, tbl[i].ctl);
      end
      checks++;
      if (nm_alu_control !== nm_exp || nm_illegal !== (nm_exp == 4'b1111)) begin
        failures++;
        $display("FAIL decode_nm[%0d] ctl=%b ill=%b exp ctl=%b", i, nm_alu_control, nm_illegal, nm_exp);
      end
    end
    go_idle();
  endtask

  task automatic test_mul();
    run_mop(3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 2);
    go_idle();
    repeat (2) @(negedge clk);
    checks++;
    if (md_result !== 32'hFFFF_FFEB || md_valid !== 1'b0) begin
      failures++;
      $display("FAIL mul_hold result=%h valid=%b exp ffffffeb/0", md_result, md_valid);
    end
    run_mop(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_mop(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    run_mop(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    go_idle();
  endtask

  task automatic test_div();
    run_mop(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_mop(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_mop(3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
    run_mop(3'b111, 32'd100, 32'd7, 32'd2, 33);
    go_idle();
  endtask

  task automatic test_corners();
    run_mop(3'b101, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
    run_mop(3'b110, MIN, 32'hFFFF_FFFF, 32'h0, 1);
    run_mop(3'b100, MIN, 32'hFFFF_FFFF, MIN, 1);
    run_mop(3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
    go_idle();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = (i == 3) ? MIN : $urandom;
      b  = (i == 3) ? 32'hFFFF_FFFF : ((i == 6) ? 32'd0 : $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 9)) : $urandom);
      run_mop(f3, a, b, model(f3, a, b), exp_lat(f3, a, b));
    end
    go_idle();
  endtask

  task automatic test_flush();
    int v0;
    v0 = vcount;
    @(posedge clk); #1;
    drive_mop(3'b100, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    checks++;
    if (md_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_valid md_valid=%b exp 0", md_valid);
    end
    run_mop(3'b000, 32'd5, 32'd6, 32'd30, 2);
    go_idle();
    repeat (30) @(negedge clk);
    checks++;
    if (vcount != v0 + 1) begin
      failures++;
      $display("FAIL flush_strobes got=%0d exp=%0d", vcount - v0, 1);
    end
  endtask

  task automatic test_exvalid_drop();
    @(posedge clk); #1;
    drive_mop(3'b000, 32'd9, 32'd9);
    sb_q.push_back(32'd81);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (md_stall !== 1'b0) begin
      failures++;
      $display("FAIL drop_stall md_stall=%b exp 0", md_stall);
    end
    @(negedge clk);
    checks++;
    if (md_valid !== 1'b1 || md_stall !== 1'b0) begin
      failures++;
      $display("FAIL drop_valid md_valid=%b md_stall=%b exp 1/0", md_valid, md_stall);
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    int v0;
    @(posedge clk); #1;
    drive_mop(3'b100, 32'd77, 32'd5);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (md_stall !== 1'b0 || md_valid !== 1'b0 || md_result !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid stall=%b valid=%b result=%h exp 0/0/0", md_stall, md_valid, md_result);
    end
    ex_valid = 1'b0;
    v0 = vcount;
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (vcount != v0) begin
      failures++;
      $display("FAIL reset_discard strobes=%0d exp 0", vcount - v0);
    end
  endtask

  task automatic test_no_m();
    @(posedge clk); #1;
    drive_mop(3'b000, 32'd2, 32'd3);
    sb_q.push_back(32'd6);
    #1;
    checks++;
    if (nm_illegal !== 1'b1 || nm_alu_control !== 4'b1111 || nm_md_stall !== 1'b0) begin
      failures++;
      $display("FAIL no_m ill=%b ctl=%b stall=%b exp 1/1111/0", nm_illegal, nm_alu_control, nm_md_stall);
    end
    @(posedge clk); #1;
    ex_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (vcount_nm != 0) begin
      failures++;
      $display("FAIL no_m_valid strobes=%0d exp 0", vcount_nm);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mul();
    test_div();
    test_corners();
    test_back_to_back();
    test_exvalid_drop();
    test_flush();
    test_reset_mid();
    test_no_m();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain pending=%0d exp 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
